computer_run_ctrl: RTL and testbench
====================================

Name: computer_run_ctrl

Overview:
- Parametrised run controller that wraps the CPU core of the emulated computer.
- Starts, pauses, single-steps and stops execution by gating the CPU's advance enable.
- Detects program termination by recognising the terminating PC loop in hardware. This generalises the single "ended" flag into ended/timeout/halt outcomes with a cycle counter.
- Sits between the computer top level and the CPU; the benches poll its status outputs.

Parameters:
- PC_W, 15, width of the program counter input.
- CNT_W, 32, width of the executed-cycle counter.
- MAX_CYCLES, 100000, enabled-cycle budget before timeout; 0 = unlimited.
- LOOP_THRESH, 64, consecutive loop matches required to declare the program ended (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a fresh run from IDLE or DONE.
- step_mode  in  1  1 = paused/single-step, 0 = free run.
- step  in  1  in PAUSE, each cycle with step=1 enables exactly one CPU cycle.
- halt_req  in  1  external stop request.
- pc  in  PC_W  CPU program counter for the instruction executing this cycle.
- cpu_en  out  1  CPU advances on this clock edge (combinational from state and step).
- running  out  1  state is RUN or PAUSE.
- ended  out  1  sticky; loop termination detected.
- timeout  out  1  sticky; cycle budget exhausted.
- cycle_count  out  CNT_W  number of enabled cycles since last start.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (async, any time, including mid-run):
  - state=IDLE; cycle_count=0; ended=0; timeout=0.
  - PC history and match counters cleared.
  - cpu_en=0 immediately.
- cpu_en = (state==RUN) | (state==PAUSE & step).
- IDLE or DONE + start:
  - go to RUN if step_mode=0, else PAUSE.
  - cycle_count, flags, history and match runs are cleared on the same edge.
  - start is ignored in RUN and PAUSE.
- RUN with step_mode=1 → PAUSE. PAUSE with step_mode=0 → RUN. Both take effect on the next edge.
- Every edge with cpu_en=1:
  - cycle_count+1, saturating at all-ones.
  - pc_d2←pc_d1, pc_d1←pc, hist_v incremented (saturates at 2).
- Loop detection, evaluated on enabled cycles only:
  - m1 = hist_v≥1 & pc==pc_d1 (self-jump, period 1).
  - m2 = hist_v≥2 & pc==pc_d2 & !m1 (two-instruction "@END;0;JMP" loop, period 2).
  - run1 = m1 ? run1+1 : 0; run2 = m2 ? run2+1 : 0.
  - When either new run value == LOOP_THRESH: go to DONE and set ended=1 on that edge. The triggering cycle still counts.
- Timeout:
  - Applies only when MAX_CYCLES≠0.
  - On the enabled edge where the new cycle_count == MAX_CYCLES: go to DONE and set timeout=1.
  - Exactly MAX_CYCLES enabled cycles occur.
- halt_req=1 in RUN or PAUSE: go to DONE on the next edge with no flag set.
  - If halt_req coincides with an enabled cycle, that cycle executes, and is counted and evaluated.
- Simultaneous events on one edge: loop and timeout may both fire, setting both flags. halt_req never masks a flag.
- DONE: cpu_en=0; outputs hold until start or reset.
- IDLE: cpu_en=0; pc is ignored.

Decomposition:
- Package computer_ctrl_pkg holds:
  - run_state_t enum (IDLE/RUN/PAUSE/DONE, 2 bits).
  - the default PC_W constant, shared with the CPU.
- One sub-module, pc_loop_detector (PC_W, LOOP_THRESH):
  - inputs: clk, reset, clear, en, pc.
  - output: loop_hit (combinational on the enabled cycle).

Test Plan (MAX_CYCLES=20, LOOP_THRESH=4 unless noted):
- Reset released, no start → state=0, cpu_en=0, cycle_count=0, ended=0, timeout=0 for 10 cycles.
- start; pc=0,1,2,… incrementing → exactly 20 cpu_en cycles, then state=3, timeout=1, ended=0, cycle_count=20, cpu_en=0 afterwards.
- start; pc=0,1,2,3,3,3,3,3 → ended=1 after the 8th enabled cycle, cycle_count=8, timeout=0. Then start again → all cleared, state=1.
- start; pc=10,11,10,11,10,11 → period-2 match, ended=1, cycle_count=6.
- start with step_mode=1; three 1-cycle step pulses 5 cycles apart → cpu_en high exactly 3 cycles, cycle_count=3, state=2. step_mode=0 → state=1 next edge.
- RUN; halt_req at cycle_count=5 → state=3, flags 0, cycle_count=6. New run; assert reset asynchronously mid-cycle at count 7 → state=0 and cycle_count=0 before the next clock edge.

Source files
------------

// File: rtl/computer_ctrl_pkg.sv
// rtl/computer_ctrl_pkg.sv - shared run-controller state encoding and PC width
package computer_ctrl_pkg;

    localparam int PC_W_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } run_state_t;

endpackage

// File: rtl/pc_loop_detector.sv
// rtl/pc_loop_detector.sv - recognises period-1 and period-2 terminating PC loops
module pc_loop_detector
    import computer_ctrl_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int LOOP_THRESH = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            en,
    input  logic [PC_W-1:0] pc,
    output logic            loop_hit
);

    localparam logic [7:0] THRESH = 8'(LOOP_THRESH);

    logic [PC_W-1:0] r_pc_d1;
    logic [PC_W-1:0] r_pc_d2;
    logic [1:0]      r_hist_v;
    logic [7:0]      r_run1;
    logic [7:0]      r_run2;

    logic            w_m1;
    logic            w_m2;
    logic [7:0]      w_run1_n;
    logic [7:0]      w_run2_n;

    // A self-jump also matches pc_d2, so the period-2 run only counts genuine two-step loops.
    assign w_m1     = (r_hist_v != 2'd0) && (pc == r_pc_d1);
    assign w_m2     = (r_hist_v == 2'd2) && (pc == r_pc_d2) && !w_m1;
    assign w_run1_n = w_m1 ? r_run1 + 8'd1 : 8'd0;
    assign w_run2_n = w_m2 ? r_run2 + 8'd1 : 8'd0;
    assign loop_hit = en && ((w_run1_n == THRESH) || (w_run2_n == THRESH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_d1  <= '0;
            r_pc_d2  <= '0;
            r_hist_v <= 2'd0;
            r_run1   <= 8'd0;
            r_run2   <= 8'd0;
        end else if (clear) begin
            r_pc_d1  <= '0;
            r_pc_d2  <= '0;
            r_hist_v <= 2'd0;
            r_run1   <= 8'd0;
            r_run2   <= 8'd0;
        end else if (en) begin
            r_pc_d2  <= r_pc_d1;
            r_pc_d1  <= pc;
            r_hist_v <= (r_hist_v == 2'd2) ? 2'd2 : r_hist_v + 2'd1;
            r_run1   <= w_run1_n;
            r_run2   <= w_run2_n;
        end
    end

endmodule

// File: rtl/computer_run_ctrl.sv
// rtl/computer_run_ctrl.sv - start/pause/step/stop controller gating the CPU advance enable
module computer_run_ctrl
    import computer_ctrl_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int CNT_W       = 32,
    parameter int MAX_CYCLES  = 100000,
    parameter int LOOP_THRESH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             halt_req,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_en,
    output logic             running,
    output logic             ended,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);

    run_state_t       r_state;
    run_state_t       w_state_n;
    logic [CNT_W-1:0] r_cycle_count;
    logic             r_ended;
    logic             r_timeout;

    logic             w_cpu_en;
    logic             w_start_fire;
    logic             w_loop_hit;
    logic             w_timeout_hit;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_cpu_en      = (r_state == ST_RUN) || ((r_state == ST_PAUSE) && step);
    assign w_start_fire  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_cnt_next    = (&r_cycle_count) ? r_cycle_count : r_cycle_count + CNT_W'(1);
    assign w_timeout_hit = (MAX_CYCLES != 0) && w_cpu_en && (w_cnt_next == MAX_C);

    pc_loop_detector #(
        .PC_W        (PC_W),
        .LOOP_THRESH (LOOP_THRESH)
    ) u_loop_det (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_start_fire),
        .en       (w_cpu_en),
        .pc       (pc),
        .loop_hit (w_loop_hit)
    );

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_state_n = step_mode ? ST_PAUSE : ST_RUN;
            end
            ST_RUN: begin
                if (w_loop_hit || w_timeout_hit || halt_req) w_state_n = ST_DONE;
                else if (step_mode)                         w_state_n = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (w_loop_hit || w_timeout_hit || halt_req) w_state_n = ST_DONE;
                else if (!step_mode)                        w_state_n = ST_RUN;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Flags are written only on enabled edges so a halt on the same edge never masks them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cycle_count <= '0;
            r_ended       <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_start_fire) begin
                r_cycle_count <= '0;
                r_ended       <= 1'b0;
                r_timeout     <= 1'b0;
            end else if (w_cpu_en) begin
                r_cycle_count <= w_cnt_next;
                if (w_loop_hit)    r_ended   <= 1'b1;
                if (w_timeout_hit) r_timeout <= 1'b1;
            end
        end
    end

    assign cpu_en      = w_cpu_en;
    assign running     = (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign ended       = r_ended;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;
    assign state       = r_state;

endmodule

// File: tb/tb_computer_run_ctrl.sv
// tb/tb_computer_run_ctrl.sv - vector table, directed corners and random run against a history model
module tb_computer_run_ctrl;

    localparam int MAXC   = 20;
    localparam int THRESH = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic        step_mode;
    logic        step;
    logic        halt_req;
    logic [14:0] pc;
    logic        cpu_en;
    logic        running;
    logic        ended;
    logic        timeout;
    logic [31:0] cycle_count;
    logic [1:0]  state;

    computer_run_ctrl #(
        .PC_W        (15),
        .CNT_W       (32),
        .MAX_CYCLES  (MAXC),
        .LOOP_THRESH (THRESH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .step_mode   (step_mode),
        .step        (step),
        .halt_req    (halt_req),
        .pc          (pc),
        .cpu_en      (cpu_en),
        .running     (running),
        .ended       (ended),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int en_seen = 0;

    // Reference model: state number, counters, and the list of PCs executed since start.
    int ms = 0;
    int mcnt = 0;
    bit mend = 0;
    bit mto = 0;
    int hist[$];

    typedef struct {
        bit start;
        int pc;
        int exp_state;
        int exp_cnt;
        bit exp_end;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_loop();
        int n = hist.size();
        int r1 = 0;
        int r2 = 0;
        for (int k = n - 1; k >= 1; k--) begin
            if (hist[k] == hist[k-1]) r1++;
            else break;
        end
        for (int k = n - 1; k >= 2; k--) begin
            if (hist[k] == hist[k-2] && hist[k] != hist[k-1]) r2++;
            else break;
        end
        return (r1 == THRESH) || (r2 == THRESH);
    endfunction

    task automatic model_reset();
        ms = 0; mcnt = 0; mend = 0; mto = 0;
        hist.delete();
    endtask

    task automatic model_edge(input bit st, input bit sm, input bit stp, input bit hr, input int p);
        bit en = (ms == 1) || (ms == 2 && stp);
        bit lp = 0;
        bit tm = 0;
        if (ms == 0 || ms == 3) begin
            if (st) begin
                ms = sm ? 2 : 1;
                mcnt = 0; mend = 0; mto = 0;
                hist.delete();
            end
        end else begin
            if (en) begin
                hist.push_back(p);
                mcnt++;
                lp = model_loop();
                tm = (mcnt == MAXC);
                if (lp) mend = 1;
                if (tm) mto = 1;
            end
            if (lp || tm || hr)   ms = 3;
            else if (ms == 1 && sm)  ms = 2;
            else if (ms == 2 && !sm) ms = 1;
        end
    endtask

    task automatic cyc(input bit st, input bit sm, input bit stp, input bit hr, input int p);
        @(negedge clk);
        start = st; step_mode = sm; step = stp; halt_req = hr; pc = 15'(p);
        #1;
        chk("cpu_en", cpu_en, ((ms == 1) || (ms == 2 && stp)) ? 1 : 0);
        if (cpu_en) en_seen++;
        @(posedge clk);
        model_edge(st, sm, stp, hr, p);
        #1;
        chk("state", state, ms);
        chk("cycle_count", cycle_count, mcnt);
        chk("ended", ended, mend);
        chk("timeout", timeout, mto);
        chk("running", running, (ms == 1 || ms == 2) ? 1 : 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input bit s, input int p, input int es, input int ec, input bit ee);
        vec_t v;
        v.start = s; v.pc = p; v.exp_state = es; v.exp_cnt = ec; v.exp_end = ee;
        return v;
    endfunction

    initial begin
        reset = 1'b1; start = 0; step_mode = 0; step = 0; halt_req = 0; pc = '0;
        tbl[0]  = mk(1, 0, 1, 0, 0);
        tbl[1]  = mk(0, 0, 1, 1, 0);
        tbl[2]  = mk(0, 1, 1, 2, 0);
        tbl[3]  = mk(0, 2, 1, 3, 0);
        tbl[4]  = mk(0, 3, 1, 4, 0);
        tbl[5]  = mk(0, 3, 1, 5, 0);
        tbl[6]  = mk(0, 3, 1, 6, 0);
        tbl[7]  = mk(0, 3, 1, 7, 0);
        tbl[8]  = mk(0, 3, 3, 8, 1);
        tbl[9]  = mk(1, 0, 1, 0, 0);
        tbl[10] = mk(0, 10, 1, 1, 0);
        tbl[11] = mk(0, 11, 1, 2, 0);
        tbl[12] = mk(0, 10, 1, 3, 0);
        tbl[13] = mk(0, 11, 1, 4, 0);
        tbl[14] = mk(0, 10, 1, 5, 0);
        tbl[15] = mk(0, 11, 3, 6, 1);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, i);
            chk("idle_state", state, 0);
            chk("idle_cnt", cycle_count, 0);
        end

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].start, 0, 0, 0, tbl[i].pc);
            chk($sformatf("tbl%0d_state", i), state, tbl[i].exp_state);
            chk($sformatf("tbl%0d_cnt", i), cycle_count, tbl[i].exp_cnt);
            chk($sformatf("tbl%0d_ended", i), ended, tbl[i].exp_end);
            chk($sformatf("tbl%0d_timeout", i), timeout, 0);
        end

        do_reset();
        cyc(1, 0, 0, 0, 0);
        en_seen = 0;
        for (int i = 0; i < 30; i++) cyc(0, 0, 0, 0, i);
        chk("to_en_cycles", en_seen, 20);
        chk("to_state", state, 3);
        chk("to_flag", timeout, 1);
        chk("to_ended", ended, 0);
        chk("to_cnt", cycle_count, 20);
        chk("to_cpu_en", cpu_en, 0);

        cyc(1, 1, 0, 0, 0);
        en_seen = 0;
        for (int i = 0; i < 15; i++) cyc(0, 1, (i % 5) == 0, 0, i * 7);
        chk("step_en_cycles", en_seen, 3);
        chk("step_cnt", cycle_count, 3);
        chk("step_state", state, 2);
        cyc(0, 0, 0, 0, 500);
        chk("unpause_state", state, 1);
        cyc(0, 0, 0, 1, 501);

        cyc(1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 0, 200 + i);
        chk("pre_halt_cnt", cycle_count, 5);
        cyc(0, 0, 0, 1, 300);
        chk("halt_state", state, 3);
        chk("halt_cnt", cycle_count, 6);
        chk("halt_ended", ended, 0);
        chk("halt_timeout", timeout, 0);

        cyc(1, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) cyc(0, 0, 0, 0, 400 + i);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_cnt", cycle_count, 0);
        chk("async_rst_cpu_en", cpu_en, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            int p;
            p = ($urandom % 2) ? int'($urandom % 3) : int'($urandom % 16);
            cyc(($urandom % 8) == 0, ($urandom % 4) == 0, $urandom % 2, ($urandom % 40) == 0, p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
